bus_rr_sched: RTL and testbench
===============================

Name: bus_rr_sched

Overview:
- Round-robin bus ownership scheduler for the shared system bus. It serves nine agents: IE, IO, DE, DO, B0, B1, B2, B3 and DMA.
- It takes level requests and one-cycle releases, and issues a single one-hot grant.
- It enforces a maximum tenure with forced revoke, and inserts bus turnaround cycles between owners.
- It sits between the cache/DMA request logic and the bus drivers. The grant id drives the bus sender field.

Parameters:
- N_AGENTS, 9, number of requesters. Fixed agent order: 0=IE, 1=IO, 2=DE, 3=DO, 4=B0, 5=B1, 6=B2, 7=B3, 8=DMA.
- MAX_HOLD, 16, maximum cycles an owner keeps the grant before forced revoke (>=2).
- TURNAROUND, 1, idle cycles after any grant drop before the next grant (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- req  in  9  level request per agent, bit index = agent id.
- rel  in  9  release strobe per agent; only the current owner's bit is honoured.
- grant  out  9  one-hot grant, all zero when no owner.
- grant_id  out  4  encoded owner id (0..8); 4'hF when no owner.
- bus_busy  out  1  high in OWNED and TURN states.
- timeout  out  1  one-cycle pulse on forced revoke.

Behaviour:
- All outputs are registered. All state changes happen on the rising clk edge.
- Reset (clr=1 at an edge, any state):
  - grant=0, grant_id=4'hF, bus_busy=0, timeout=0.
  - state=IDLE, tenure counter=0, turnaround counter=0, round-robin pointer ptr=0.
  - clr has priority over every other event, including a mid-tenure owner. No release handshake is needed after reset.
- States: IDLE, OWNED, TURN.
- IDLE:
  - If req != 0 at an edge, winner = first set bit scanning ptr, ptr+1, ..., 8, 0, ..., ptr-1.
  - After that edge: state=OWNED, grant=one-hot(winner), grant_id=winner, bus_busy=1, tenure=0.
  - Request-to-grant latency is one edge.
  - If req == 0, the block stays in IDLE with outputs at reset values.
- OWNED:
  - tenure increments every cycle.
  - Normal release: rel[owner]=1 at an edge drops the grant.
  - Forced revoke: tenure==MAX_HOLD-1 at an edge with no release drops the grant and makes timeout=1 for exactly one cycle.
  - On either drop, after the edge: grant=0, grant_id=4'hF, bus_busy=1, state=TURN, turnaround counter=TURNAROUND-1, ptr=(owner+1) mod 9 (owner 8 wraps to ptr 0).
  - Release and timeout on the same edge counts as a release: timeout stays 0.
  - rel bits of non-owners are ignored.
  - The owner deasserting req does not release the bus.
  - req of other agents is ignored while OWNED; no preemption.
- TURN:
  - Decrement the turnaround counter each edge. At an edge with counter==0: state=IDLE, bus_busy=0.
  - Arbitration happens only in IDLE, so the grant gap is TURNAROUND+1 edges minimum.
  - Requests held during OWNED/TURN are served in the first IDLE cycle.
- Invariants: grant is always zero or one-hot. grant_id is consistent with grant. The timeout pulse never lasts more than one cycle.
- Tenure counter width: clog2(MAX_HOLD). It never wraps, since it resets on grant.

Test Plan:
- Single requester: reset, then req=9'h004 (DE) at edge 1 -> after edge 1 grant=9'h004, grant_id=2, bus_busy=1. rel[2] pulse at edge 4 -> grant=0, grant_id=F. After one TURN cycle, bus_busy=0.
- Round robin fairness: req=9'h1FF held; each owner releases after 2 cycles -> grant_id sequence 0,1,2,...,8,0. No agent is skipped or repeated.
- Pointer wrap: after DMA (8) releases, req=9'h101 -> next grant_id=0. Then after 0 releases with req=9'h101 still set -> grant_id=8.
- Forced revoke: MAX_HOLD=16, IO granted and never releases -> grant drops at tenure 15. timeout=1 for one cycle. Next grant goes to another pending requester ahead of IO.
- Stray release and same-edge events: owner IE; rel=9'h010 (B0) -> grant unchanged. rel[0] on the timeout edge -> timeout stays 0.
- Reset mid-ownership: B3 owns with tenure=5, clr=1 for one edge -> grant=0, grant_id=F, bus_busy=0, ptr=0. With req=9'h0FF after reset -> grant_id=0.

Source files
------------

// File: rtl/bus_rr_sched.sv
// Round-robin bus ownership scheduler: one owner at a time, bounded tenure
// with forced revoke, and idle turnaround cycles between owners.
module bus_rr_sched #(
  parameter int N_AGENTS   = 9,
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [N_AGENTS-1:0] req,
  input  logic [N_AGENTS-1:0] rel,
  output logic [N_AGENTS-1:0] grant,
  output logic [3:0]          grant_id,
  output logic                bus_busy,
  output logic                timeout
);

  localparam int TW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int CW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [3:0] NO_OWNER = 4'hF;

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  state_t              state, state_n;
  logic [TW-1:0]       tenure, tenure_n;
  logic [CW-1:0]       turn_cnt, turn_cnt_n;
  logic [3:0]          ptr, ptr_n;
  logic [N_AGENTS-1:0] grant_n;
  logic [3:0]          grant_id_n;
  logic                bus_busy_n, timeout_n;

  logic                win_found;
  logic [3:0]          win_id;
  logic                rel_hit;
  logic                hold_expired;
  logic [3:0]          ptr_after_owner;

  // Rotating priority scan: first requester at or after ptr, wrapping at N_AGENTS.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < N_AGENTS; k++) begin
      logic [4:0] idx;
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'(N_AGENTS)) idx = idx - 5'(N_AGENTS);
      if (!win_found && req[idx[3:0]]) begin
        win_found = 1'b1;
        win_id    = idx[3:0];
      end
    end
  end

  // Release only counts for the bit matching the current one-hot grant.
  assign rel_hit         = |(rel & grant);
  assign hold_expired    = (tenure == TW'(MAX_HOLD - 1));
  assign ptr_after_owner = (grant_id == 4'(N_AGENTS - 1)) ? 4'd0 : grant_id + 4'd1;

  // Next-state and next-output logic; registered outputs hold by default.
  always_comb begin
    state_n    = state;
    tenure_n   = tenure;
    turn_cnt_n = turn_cnt;
    ptr_n      = ptr;
    grant_n    = grant;
    grant_id_n = grant_id;
    bus_busy_n = bus_busy;
    timeout_n  = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_n             = OWNED;
          grant_n             = '0;
          grant_n[win_id]     = 1'b1;
          grant_id_n          = win_id;
          bus_busy_n          = 1'b1;
          tenure_n            = '0;
        end
      end
      OWNED: begin
        if (rel_hit || hold_expired) begin
          // Release wins over a coincident timeout: no pulse in that case.
          timeout_n  = !rel_hit;
          state_n    = TURN;
          grant_n    = '0;
          grant_id_n = NO_OWNER;
          bus_busy_n = 1'b1;
          turn_cnt_n = CW'(TURNAROUND - 1);
          ptr_n      = ptr_after_owner;
        end else begin
          tenure_n = tenure + TW'(1);
        end
      end
      TURN: begin
        if (turn_cnt == '0) begin
          state_n    = IDLE;
          bus_busy_n = 1'b0;
        end else begin
          turn_cnt_n = turn_cnt - CW'(1);
        end
      end
      default: begin
        state_n    = IDLE;
        grant_n    = '0;
        grant_id_n = NO_OWNER;
        bus_busy_n = 1'b0;
      end
    endcase
  end

  // State and output registers; clr overrides everything, including an active owner.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      tenure   <= '0;
      turn_cnt <= '0;
      ptr      <= '0;
      grant    <= '0;
      grant_id <= NO_OWNER;
      bus_busy <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      tenure   <= tenure_n;
      turn_cnt <= turn_cnt_n;
      ptr      <= ptr_n;
      grant    <= grant_n;
      grant_id <= grant_id_n;
      bus_busy <= bus_busy_n;
      timeout  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_bus_rr_sched.sv
// Bench for bus_rr_sched: behavioural ownership model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bus_rr_sched;

  localparam int NA = 9;
  localparam int MAX_HOLD = 16;
  localparam int TURNAROUND = 1;

  logic          clk = 1'b0;
  logic          clr;
  logic [NA-1:0] req, rel;
  logic [NA-1:0] grant;
  logic [3:0]    grant_id;
  logic          bus_busy, timeout;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  bus_rr_sched #(.N_AGENTS(NA), .MAX_HOLD(MAX_HOLD), .TURNAROUND(TURNAROUND)) dut (
    .clk(clk), .clr(clr), .req(req), .rel(rel),
    .grant(grant), .grant_id(grant_id), .bus_busy(bus_busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Model: who owns the bus, how many cycles it has shown the grant,
  // how many busy-but-ownerless cycles remain, and where the scan starts.
  int m_owner = -1;
  int m_age   = 0;
  int m_gap   = 0;
  int m_ptr   = 0;
  bit m_to    = 0;

  always @(posedge clk) begin
    if (clr) begin
      m_owner = -1; m_age = 0; m_gap = 0; m_ptr = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_owner >= 0) begin
        if (rel[m_owner] || m_age == MAX_HOLD) begin
          m_to    = !rel[m_owner];
          m_ptr   = (m_owner + 1) % NA;
          m_owner = -1;
          m_gap   = TURNAROUND;
        end else begin
          m_age++;
        end
      end else if (m_gap > 0) begin
        m_gap--;
      end else if (req != 0) begin
        for (int k = 0; k < NA; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % NA]) m_owner = (m_ptr + k) % NA;
        end
        m_age = 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [NA-1:0] e_grant;
      logic [3:0]    e_id;
      logic          e_busy;
      e_grant = '0;
      e_id    = 4'hF;
      if (m_owner >= 0) begin
        e_grant[m_owner] = 1'b1;
        e_id = 4'(m_owner);
      end
      e_busy = (m_owner >= 0) || (m_gap > 0);
      n_cmp++;
      if (grant !== e_grant || grant_id !== e_id || bus_busy !== e_busy || timeout !== m_to) begin
        n_bad++;
        $display("FAIL model t=%0t got grant=%h id=%h busy=%b to=%b, want grant=%h id=%h busy=%b to=%b",
                 $time, grant, grant_id, bus_busy, timeout, e_grant, e_id, e_busy, m_to);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic [NA-1:0] r, input logic [NA-1:0] l);
    req = r;
    rel = l;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Idle with request r until a grant appears, bounded.
  task automatic wait_grant(input logic [NA-1:0] r, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (grant != 0) begin
        ok = 1;
        break;
      end
      step(r, '0);
    end
    if (!ok) chk({nm, "_wait_timeout"}, 0, 1);
  endtask

  initial begin
    int cnt;
    clr = 1'b1; req = '0; rel = '0;
    step('0, '0);
    chk_en = 1;
    step('0, '0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_id", int'(grant_id), 15);
    chk("rst_busy", int'(bus_busy), 0);
    chk("rst_to", int'(timeout), 0);
    clr = 1'b0;

    // Single requester DE
    step(9'h004, '0);
    chk("de_grant", int'(grant), 9'h004);
    chk("de_id", int'(grant_id), 2);
    chk("de_busy", int'(bus_busy), 1);
    step(9'h004, '0);
    step(9'h004, '0);
    step('0, 9'h004);
    chk("de_rel_grant", int'(grant), 0);
    chk("de_rel_id", int'(grant_id), 15);
    chk("de_turn_busy", int'(bus_busy), 1);
    step('0, '0);
    chk("de_idle_busy", int'(bus_busy), 0);

    // Round robin over all agents, each releasing after two cycles
    clr = 1'b1;
    step('0, '0);
    clr = 1'b0;
    for (int g = 0; g < NA; g++) begin
      wait_grant(9'h1FF, "rr");
      chk("rr_id", int'(grant_id), g);
      step(9'h1FF, '0);
      step(9'h1FF, grant);
    end

    // Pointer wrap after DMA
    wait_grant(9'h101, "wrap0");
    chk("wrap_id0", int'(grant_id), 0);
    step(9'h101, 9'h001);
    wait_grant(9'h101, "wrap8");
    chk("wrap_id8", int'(grant_id), 8);
    step('0, 9'h100);

    // Forced revoke of IO, B0 pending
    wait_grant(9'h002, "io");
    chk("io_id", int'(grant_id), 1);
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step(9'h012, '0);
      if (grant == 0) break;
      cnt++;
    end
    chk("revoke_len", cnt, MAX_HOLD);
    chk("revoke_to", int'(timeout), 1);
    step(9'h012, '0);
    chk("revoke_to_pulse", int'(timeout), 0);
    wait_grant(9'h012, "after_revoke");
    chk("after_revoke_id", int'(grant_id), 4);
    step('0, 9'h010);
    step('0, '0);
    step('0, '0);

    // Stray release and release on the timeout edge
    wait_grant(9'h001, "ie");
    chk("ie_id", int'(grant_id), 0);
    for (int i = 1; i <= MAX_HOLD - 1; i++) begin
      step(9'h001, (i == 1) ? 9'h010 : 9'h000);
      if (i == 1) chk("stray_rel", int'(grant), 9'h001);
    end
    step(9'h001, 9'h001);
    chk("same_edge_grant", int'(grant), 0);
    chk("same_edge_to", int'(timeout), 0);
    step('0, '0);
    step('0, '0);

    // Reset during B3 ownership
    wait_grant(9'h080, "b3");
    chk("b3_id", int'(grant_id), 7);
    for (int i = 0; i < 5; i++) step(9'h080, '0);
    clr = 1'b1;
    step(9'h0FF, '0);
    chk("mid_rst_grant", int'(grant), 0);
    chk("mid_rst_id", int'(grant_id), 15);
    chk("mid_rst_busy", int'(bus_busy), 0);
    clr = 1'b0;
    step(9'h0FF, '0);
    chk("post_rst_id", int'(grant_id), 0);
    step('0, '0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
